// File: rtl/pq_arbiter.sv
// pq_arbiter: round-robin front end sharing one pulse-protocol priority queue
// among NREQ requesters. One operation is in flight at a time:
// IDLE -> ISSUE (strobe) -> GAP -> WAIT (while busy) -> RESP, or IDLE -> RESP
// directly for a rejected request.
// Optional build macro PQ_ARB_STATS_EN adds saturating enq/deq/reject counters
// on outputs stat_enq, stat_deq and stat_rej.
module pq_arbiter #(
  parameter int NREQ = 4,
  parameter int KW   = 16,
  parameter int VW   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [NREQ*(KW+VW)-1:0]  req_kv,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic                     rsp_ok,
  output logic [KW+VW-1:0]         rsp_kv,
  output logic                     pq_enq,
  output logic                     pq_deq,
  output logic [KW+VW-1:0]         pq_kvi,
  input  logic [KW+VW-1:0]         pq_kvo,
  input  logic                     pq_busy,
  input  logic                     pq_empty,
  input  logic                     pq_full
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [15:0]              stat_enq,
  output logic [15:0]              stat_deq,
  output logic [15:0]              stat_rej
`endif
);

  localparam int KVW = KW + VW;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           state_reg;
  logic [IW-1:0]    ptr_reg;        // last granted requester; also owner of the op in flight
  logic [1:0]       op_reg;         // latched operation of the op in flight
  logic [KVW-1:0]   cap_reg;        // head captured during ISSUE for deq/replace
  logic [NREQ-1:0]  rsp_valid_reg;
  logic             rsp_ok_reg;
  logic [KVW-1:0]   rsp_kv_reg;
  logic             pq_enq_reg;
  logic             pq_deq_reg;
  logic [KVW-1:0]   pq_kvi_reg;     // latched request kv, presented to the queue in ISSUE

  logic             grant_found;
  logic [IW-1:0]    grant_idx;
  logic             accept;
  logic [1:0]       sel_op;
  logic [KVW-1:0]   sel_kv;
  logic             sel_reject;

  function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int cand;
      cand = (int'(ptr_reg) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // A grant happens only from IDLE while the queue reports idle.
  assign accept = (state_reg == S_IDLE) && !pq_busy && grant_found;
  assign sel_op = req_op[2*int'(grant_idx) +: 2];
  assign sel_kv = req_kv[KVW*int'(grant_idx) +: KVW];

  // Legality against the queue status seen in the acceptance cycle.
  always_comb begin
    sel_reject = 1'b0;
    case (sel_op)
      OP_ENQ:  sel_reject = pq_full;
      OP_DEQ:  sel_reject = pq_empty;
      OP_REP:  sel_reject = pq_empty;   // replace into a full queue is fine
      default: sel_reject = 1'b1;       // reserved opcode
    endcase
  end

  // The acceptance pulse is the only combinational output; held low in reset.
  assign req_ready = (accept && rst_n) ? to_onehot(grant_idx) : '0;

  // Operation sequencer with registered strobes and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= IW'(NREQ - 1);
      op_reg        <= '0;
      cap_reg       <= '0;
      rsp_valid_reg <= '0;
      rsp_ok_reg    <= 1'b0;
      rsp_kv_reg    <= '0;
      pq_enq_reg    <= 1'b0;
      pq_deq_reg    <= 1'b0;
      pq_kvi_reg    <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            ptr_reg <= grant_idx;
            op_reg  <= sel_op;
            cap_reg <= '0;
            if (sel_reject) begin
              state_reg     <= S_RESP;
              rsp_valid_reg <= to_onehot(grant_idx);
              rsp_ok_reg    <= 1'b0;
              rsp_kv_reg    <= '0;
            end else begin
              state_reg  <= S_ISSUE;
              pq_enq_reg <= (sel_op == OP_ENQ) || (sel_op == OP_REP);
              pq_deq_reg <= (sel_op == OP_DEQ) || (sel_op == OP_REP);
              pq_kvi_reg <= sel_kv;
            end
          end
        end
        S_ISSUE: begin
          // Head is sampled while the strobe is on the queue's inputs.
          pq_enq_reg <= 1'b0;
          pq_deq_reg <= 1'b0;
          pq_kvi_reg <= '0;
          if (op_reg != OP_ENQ) begin
            cap_reg <= pq_kvo;
          end
          state_reg <= S_GAP;
        end
        S_GAP: begin
          // Queue may not have raised busy yet, so it is not looked at here.
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (!pq_busy) begin
            state_reg     <= S_RESP;
            rsp_valid_reg <= to_onehot(ptr_reg);
            rsp_ok_reg    <= 1'b1;
            rsp_kv_reg    <= cap_reg;
          end
        end
        S_RESP: begin
          state_reg     <= S_IDLE;
          rsp_valid_reg <= '0;
          rsp_ok_reg    <= 1'b0;
          rsp_kv_reg    <= '0;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_ok    = rsp_ok_reg;
  assign rsp_kv    = rsp_kv_reg;
  assign pq_enq    = pq_enq_reg;
  assign pq_deq    = pq_deq_reg;
  assign pq_kvi    = pq_kvi_reg;

`ifdef PQ_ARB_STATS_EN
  logic [15:0] stat_enq_reg;
  logic [15:0] stat_deq_reg;
  logic [15:0] stat_rej_reg;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Tally each finished operation during its response cycle; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_enq_reg <= '0;
      stat_deq_reg <= '0;
      stat_rej_reg <= '0;
    end else if (state_reg == S_RESP) begin
      if (!rsp_ok_reg) begin
        stat_rej_reg <= sat_inc(stat_rej_reg);
      end else begin
        if ((op_reg == OP_ENQ) || (op_reg == OP_REP)) begin
          stat_enq_reg <= sat_inc(stat_enq_reg);
        end
        if ((op_reg == OP_DEQ) || (op_reg == OP_REP)) begin
          stat_deq_reg <= sat_inc(stat_deq_reg);
        end
      end
    end
  end

  assign stat_enq = stat_enq_reg;
  assign stat_deq = stat_deq_reg;
  assign stat_rej = stat_rej_reg;
`endif

endmodule
